mul_32bits_seq: RTL



---
 rtl/mul_32bits_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/mul_32bits_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier sharing one adder_32bits.
// Optional build macro MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.

module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, ci};
endmodule

module mul_32bits_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] m_reg, h_reg, q_reg;
  logic [5:0]  k_reg;
  logic [63:0] p_reg;

  logic [31:0] add_b, sum;
  logic        carry;
  logic [63:0] shifted;
  logic        last_iter;
  logic        exit_now;

  assign add_b = q_reg[0] ? m_reg : 32'd0;

  adder_32bits u_add (
    .a  (h_reg),
    .b  (add_b),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  // Carry-out becomes the new MSB so the 65-bit sum never loses a bit.
  assign shifted   = {carry, sum, q_reg[31:1]};
  assign last_iter = (k_reg == 6'd31);

`ifdef MUL_EARLY_EXIT_EN
  logic [31:0] rem_mask;
  logic [63:0] early_p;
  assign rem_mask = 32'hFFFF_FFFF >> k_reg;
  assign exit_now = ((q_reg & rem_mask) == 32'd0);
  // Partial sum sits 32-k bits above the product alignment.
  assign early_p  = {h_reg, q_reg} >> (7'd32 - {1'b0, k_reg});
`else
  assign exit_now = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (exit_now || last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= 32'd0;
      h_reg     <= 32'd0;
      q_reg     <= 32'd0;
      k_reg     <= 6'd0;
      p_reg     <= 64'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            h_reg <= 32'd0;
            k_reg <= 6'd0;
          end
        end
        RUN: begin
`ifdef MUL_EARLY_EXIT_EN
          if (exit_now) begin
            p_reg <= early_p;
          end else
`endif
          begin
            h_reg <= shifted[63:32];
            q_reg <= shifted[31:0];
            k_reg <= k_reg + 6'd1;
            if (last_iter) p_reg <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign p    = p_reg;
endmodule
